// File: rtl/oc8051_ifetch_x_if.sv
// oc8051_ifetch_x_if: core-side fetch handshake plus 8-bit external ROM bus
// for the oc8051 external instruction fetch unit.
//   istb_i/iadr_i        : 3-byte window request from the core
//   op1_x..op3_x, iack_o : fetched window bytes and one-cycle acknowledge
//   wbi_*                : Wishbone-style byte read bus toward external ROM
// modport master : the fetch unit itself
// modport slave  : the environment (core side and ROM side)
interface oc8051_ifetch_x_if;
   logic        istb_i;
   logic [15:0] iadr_i;
   logic [7:0]  op1_x;
   logic [7:0]  op2_x;
   logic [7:0]  op3_x;
   logic        iack_o;
   logic [15:0] wbi_adr_o;
   logic [7:0]  wbi_dat_i;
   logic        wbi_cyc_o;
   logic        wbi_stb_o;
   logic        wbi_ack_i;

   modport master (
      input  istb_i, iadr_i, wbi_dat_i, wbi_ack_i,
      output op1_x, op2_x, op3_x, iack_o, wbi_adr_o, wbi_cyc_o, wbi_stb_o
   );

   modport slave (
      output istb_i, iadr_i, wbi_dat_i, wbi_ack_i,
      input  op1_x, op2_x, op3_x, iack_o, wbi_adr_o, wbi_cyc_o, wbi_stb_o
   );
endinterface

// File: rtl/oc8051_ifetch_x.sv
// oc8051_ifetch_x: external instruction fetch unit. Turns 3-byte window
// requests into byte reads on the external ROM bus, keeping a 3-byte window
// buffer so bytes overlapping the previous window are not refetched.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   ifc  : oc8051_ifetch_x_if.master (core request/ack + ROM bus)
// Build option: OC8051_IFETCH_REUSE_EN enables exact-hit and shift-reuse;
// without it every request refetches all three bytes.
module oc8051_ifetch_x (
   input  logic                     clk,
   input  logic                     rst,
   oc8051_ifetch_x_if.master        ifc
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ACK   = 2'd2
   } state_e;

   state_e                state_q;
   logic [AW-1:0]         base_q;
   logic [2:0][DW-1:0]    w_q;
   logic [2:0]            v_q;
   logic [1:0]            idx_q;
   logic [DW-1:0]         op1_q, op2_q, op3_q;
   logic                  iack_q;
   logic                  cyc_q;
   logic                  stb_q;
   logic [AW-1:0]         adr_q;

   // Window as it would look after rebasing to iadr_i
   logic [2:0][DW-1:0]    w_d;
   logic [2:0]            v_d;
   logic                  hit_d;
   logic [1:0]            start_d;

`ifdef OC8051_IFETCH_REUSE_EN
   logic [AW-1:0]         diff_d;
`endif

   // Rebase lookup. Valid bits always form a prefix (fetches run upward from
   // the first invalid index), so a shift keeps whatever prefix survives and
   // fetching resumes at the first hole; offset 0 with a partial window (after
   // an abort) therefore refetches only the missing tail.
   always_comb begin
      w_d = w_q;
      v_d = 3'b000;
`ifdef OC8051_IFETCH_REUSE_EN
      diff_d = ifc.iadr_i - base_q;
      case (diff_d)
         16'd0: begin
            v_d = v_q;
         end
         16'd1: begin
            w_d[0] = w_q[1];
            w_d[1] = w_q[2];
            v_d    = {1'b0, v_q[2:1]};
         end
         16'd2: begin
            w_d[0] = w_q[2];
            v_d    = {2'b00, v_q[2]};
         end
         default: v_d = 3'b000;
      endcase
`endif
      hit_d = &v_d;
      if (!v_d[0])      start_d = 2'd0;
      else if (!v_d[1]) start_d = 2'd1;
      else              start_d = 2'd2;
   end

   // Fetch state machine with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         w_q     <= '0;
         v_q     <= '0;
         idx_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         op3_q   <= '0;
         iack_q  <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         adr_q   <= '0;
      end else begin
         iack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ifc.istb_i) begin
                  base_q <= ifc.iadr_i;
                  w_q    <= w_d;
                  v_q    <= v_d;
                  if (hit_d) begin
                     state_q <= ST_ACK;
                     iack_q  <= 1'b1;
                     op1_q   <= w_d[0];
                     op2_q   <= w_d[1];
                     op3_q   <= w_d[2];
                  end else begin
                     state_q <= ST_FETCH;
                     idx_q   <= start_d;
                     adr_q   <= ifc.iadr_i + AW'(start_d);
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (ifc.wbi_ack_i) begin
                  w_q[idx_q] <= ifc.wbi_dat_i;
                  v_q[idx_q] <= 1'b1;
                  if (!ifc.istb_i) begin
                     // Request withdrawn: keep the captured byte, no ack
                     state_q <= ST_IDLE;
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                  end else if (idx_q == 2'd2) begin
                     state_q <= ST_ACK;
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                     iack_q  <= 1'b1;
                     op1_q   <= w_q[0];
                     op2_q   <= w_q[1];
                     op3_q   <= ifc.wbi_dat_i;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                     adr_q <= base_q + AW'(idx_q + 2'd1);
                  end
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               cyc_q   <= 1'b0;
               stb_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ifc.op1_x     = op1_q;
   assign ifc.op2_x     = op2_q;
   assign ifc.op3_x     = op3_q;
   assign ifc.iack_o    = iack_q;
   assign ifc.wbi_adr_o = adr_q;
   assign ifc.wbi_cyc_o = cyc_q;
   assign ifc.wbi_stb_o = stb_q;

endmodule

// File: tb/tb_oc8051_ifetch_x.sv
// tb_oc8051_ifetch_x: self-checking bench for oc8051_ifetch_x. A ROM model
// answers bus reads with configurable wait states; expected bus addresses and
// expected window bytes are queued when a request is issued and popped when
// the DUT reads the bus or pulses iack_o.
module tb_oc8051_ifetch_x;

`ifdef OC8051_IFETCH_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   oc8051_ifetch_x_if ifc ();

   oc8051_ifetch_x dut (
      .clk (clk),
      .rst (rst),
      .ifc (ifc)
   );

   always #5 clk = ~clk;

   logic [7:0]  rom [65536];
   exp_t        exp_q [$];
   logic [15:0] adr_exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          ws = 0;
   int          wcnt = 0;

   // ROM responder: acks after ws wait cycles, checks address order/stability
   always @(negedge clk) begin
      logic [15:0] ea;
      if (!rst && ifc.wbi_cyc_o && ifc.wbi_stb_o) begin
         if (wcnt >= ws) begin
            checks++;
            if (adr_exp_q.size() == 0) begin
               errors++;
               $display("FAIL bus_read unexpected read at %h", ifc.wbi_adr_o);
            end else begin
               ea = adr_exp_q.pop_front();
               if (ifc.wbi_adr_o !== ea) begin
                  errors++;
                  $display("FAIL bus_adr got %h expected %h", ifc.wbi_adr_o, ea);
               end
            end
            ifc.wbi_ack_i = 1'b1;
            ifc.wbi_dat_i = rom[ifc.wbi_adr_o];
            wcnt = 0;
         end else begin
            if (adr_exp_q.size() != 0) begin
               checks++;
               if (ifc.wbi_adr_o !== adr_exp_q[0]) begin
                  errors++;
                  $display("FAIL bus_adr_wait got %h expected %h", ifc.wbi_adr_o, adr_exp_q[0]);
               end
            end
            ifc.wbi_ack_i = 1'b0;
            wcnt++;
         end
      end else begin
         ifc.wbi_ack_i = 1'b0;
         wcnt = 0;
      end
   end

   // Output monitor: every iack_o pulse must match the oldest expected window
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ifc.iack_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL iack unexpected pulse ops %h %h %h", ifc.op1_x, ifc.op2_x, ifc.op3_x);
         end else begin
            e = exp_q.pop_front();
            if ({ifc.op1_x, ifc.op2_x, ifc.op3_x} !== {e.b0, e.b1, e.b2}) begin
               errors++;
               $display("FAIL ops got %h %h %h expected %h %h %h",
                        ifc.op1_x, ifc.op2_x, ifc.op3_x, e.b0, e.b1, e.b2);
            end
         end
      end
   end

   // Issue one request; bytes from index 'first' upward are expected on the bus
   task automatic do_req(input logic [15:0] a, input int first, input string nm);
      int   lat;
      int   n;
      bit   got;
      exp_t e;
      lat = (3 - first) * (ws + 1) + 1;
      for (int k = first; k < 3; k++) adr_exp_q.push_back(a + 16'(k));
      e.b0 = rom[a];
      e.b1 = rom[a + 16'd1];
      e.b2 = rom[a + 16'd2];
      exp_q.push_back(e);
      @(negedge clk);
      ifc.istb_i = 1'b1;
      ifc.iadr_i = a;
      n   = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (ifc.iack_o === 1'b1) got = 1'b1;
      end
      ifc.istb_i = 1'b0;
      checks++;
      if (!got || n != lat) begin
         errors++;
         $display("FAIL %s latency got %0d (seen %0d) expected %0d", nm, n, got, lat);
         exp_q.delete();
      end
      checks++;
      if (adr_exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s bus_reads %0d expected reads missing", nm, adr_exp_q.size());
         adr_exp_q.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifc.op1_x, ifc.op2_x, ifc.op3_x, ifc.iack_o, ifc.wbi_cyc_o, ifc.wbi_stb_o, ifc.wbi_adr_o} !== 43'd0) begin
         errors++;
         $display("FAIL reset_outputs got ops %h %h %h iack %b cyc %b stb %b adr %h expected all 0",
                  ifc.op1_x, ifc.op2_x, ifc.op3_x, ifc.iack_o, ifc.wbi_cyc_o, ifc.wbi_stb_o, ifc.wbi_adr_o);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ifc.iack_o, ifc.wbi_cyc_o} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset got iack %b cyc %b expected 0 0", ifc.iack_o, ifc.wbi_cyc_o);
      end
   endtask

   task automatic test_cold_miss;
      do_req(16'h0100, 0, "cold_miss");
   endtask

   task automatic test_repeat_shift;
      do_req(16'h0100, REUSE ? 3 : 0, "repeat_exact");
      do_req(16'h0101, REUSE ? 2 : 0, "shift1");
   endtask

   task automatic test_wait_states;
      ws = 2;
      do_req(16'h2000, 0, "wait_states");
      ws = 0;
   endtask

   task automatic test_wrap;
      do_req(16'hFFFF, 0, "wrap");
   endtask

   task automatic test_abort;
      adr_exp_q.push_back(16'h3000);
      adr_exp_q.push_back(16'h3001);
      @(negedge clk);
      ifc.istb_i = 1'b1;
      ifc.iadr_i = 16'h3000;
      @(negedge clk);
      @(negedge clk);
      ifc.istb_i = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if ({ifc.wbi_cyc_o, ifc.wbi_stb_o} !== 2'b00) begin
         errors++;
         $display("FAIL abort_cyc got cyc %b stb %b expected 0 0", ifc.wbi_cyc_o, ifc.wbi_stb_o);
      end
      checks++;
      if (adr_exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_reads got %0d missing expected 0", adr_exp_q.size());
         adr_exp_q.delete();
      end
      do_req(16'h3000, REUSE ? 2 : 0, "abort_rereq");
   endtask

   task automatic test_reset_mid_fetch;
      ws = 3;
      adr_exp_q.push_back(16'h4000);
      @(negedge clk);
      ifc.istb_i = 1'b1;
      ifc.iadr_i = 16'h4000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({ifc.op1_x, ifc.op2_x, ifc.op3_x, ifc.iack_o, ifc.wbi_cyc_o, ifc.wbi_stb_o, ifc.wbi_adr_o} !== 43'd0) begin
         errors++;
         $display("FAIL reset_mid_fetch got ops %h %h %h iack %b cyc %b stb %b adr %h expected all 0",
                  ifc.op1_x, ifc.op2_x, ifc.op3_x, ifc.iack_o, ifc.wbi_cyc_o, ifc.wbi_stb_o, ifc.wbi_adr_o);
      end
      ifc.istb_i = 1'b0;
      adr_exp_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      ws  = 0;
      do_req(16'h0100, 0, "post_reset_miss");
   endtask

   task automatic test_back_to_back;
      do_req(16'h0102, REUSE ? 1 : 0, "shift2");
      do_req(16'h0102, REUSE ? 3 : 0, "shift2_repeat");
      do_req(16'h0104, REUSE ? 1 : 0, "shift2_again");
      do_req(16'h0200, 0, "far_miss");
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = 8'((i * 37 + 11) ^ (i >> 8));
      rom[16'h0100] = 8'h02;
      rom[16'h0101] = 8'h12;
      rom[16'h0102] = 8'h34;
      ifc.istb_i    = 1'b0;
      ifc.iadr_i    = 16'h0000;
      ifc.wbi_ack_i = 1'b0;
      ifc.wbi_dat_i = 8'h00;
      test_reset();
      test_cold_miss();
      test_repeat_shift();
      test_wait_states();
      test_wrap();
      test_abort();
      test_reset_mid_fetch();
      test_back_to_back();
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oc8051_ifetch_x.md
# oc8051_ifetch_x

External instruction fetch unit. It sits directly upstream of the core's instruction select stage and serves the external-ROM path: `op1_x`, `op2_x`, `op3_x` and `iack`. It converts each 3-byte instruction-window request from the core into byte reads on an 8-bit Wishbone-style external ROM bus. A 3-byte window buffer avoids refetching bytes that overlap the previous window.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- istb_i  in  1  fetch request strobe from the core (already gated to 0 when internal ROM is selected)
- iadr_i  in  16  address of first instruction byte; must be stable while istb_i=1
- op1_x  out  8  byte at iadr_i
- op2_x  out  8  byte at iadr_i+1
- op3_x  out  8  byte at iadr_i+2
- iack_o  out  1  one-cycle pulse; op1_x..op3_x are valid for the request
- wbi_adr_o  out  16  external ROM byte address
- wbi_dat_i  in  8  external ROM read data
- wbi_cyc_o  out  1  bus cycle active
- wbi_stb_o  out  1  bus strobe
- wbi_ack_i  in  1  bus acknowledge; data is captured in the same cycle

## Operation
- **Window:** `base[15:0]`, bytes `w0..w2`, valid bits `v0..v2`. Window byte k holds address base+k, modulo 2^16.
- **States:**
  - IDLE: istb_i is sampled here only.
  - FETCH: bus active.
  - ACK: drives the iack_o pulse.
- **IDLE with istb_i=1, A=iadr_i:**
  - Exact hit (A==base, v0..v2 all set): go to ACK.
  - Shift-reuse: A==base+1 or A==base+2 with the overlapping bytes valid. Shift the window down by 1 or 2, set base=A, clear the vacated valid bits, go to FETCH starting at the first invalid index.
  - Otherwise: set base=A, clear all valid bits, go to FETCH at index 0.
- **FETCH:**
  - wbi_cyc_o=wbi_stb_o=1, wbi_adr_o=base+idx.
  - On wbi_ack_i: w[idx]<=wbi_dat_i, v[idx]<=1, idx++.
  - After index 2 is acknowledged: go to ACK.
  - cyc/stb stay high back-to-back across bytes; the address advances the cycle after each ack.
- **ACK:**
  - Load op1_x..op3_x from w0..w2 in the same edge that enters ACK, so they are valid while iack_o=1.
  - iack_o=1 for one cycle, then return to IDLE.
- **Output hold:** op1_x..op3_x hold their values until the next ACK.
- **Wait-state tolerance:** the block tolerates any number of wait states (wbi_ack_i low).

## Timing
- **Reset values:**
  - All outputs 0: op*_x=0, iack_o=0, wbi_cyc_o=0, wbi_stb_o=0, wbi_adr_o=0.
  - State IDLE, v0..v2=0, base=0.
- **Hit latency:** istb_i sampled at edge n → iack_o high in cycle n+1.
- **Miss latency (zero-wait bus):** for k bytes fetched, stb is high in cycles n+1..n+k and iack_o is high in cycle n+k+1. Each wait state adds one cycle.
- **istb_i held high in the ACK cycle:** not a new request. It is resampled in IDLE the following cycle, and a repeat of the same address is an exact hit.
- **istb_i dropping during FETCH (abort):**
  - The byte in flight completes: remain in FETCH until wbi_ack_i, capture the byte and set its valid bit.
  - Then return to IDLE without an iack_o pulse. Remaining bytes stay invalid.
- **Address wrap:** base+k wraps FFFF→0000. A=FFFF fetches FFFF, 0000, 0001.
- **Reset mid-FETCH:** cyc/stb drop immediately (asynchronous). Late wbi_ack_i after reset is ignored.

## Configuration
- **`OC8051_IFETCH_REUSE_EN` defined:** exact-hit and shift-reuse behave as described.
- **`OC8051_IFETCH_REUSE_EN` undefined:**
  - Every request refetches all 3 bytes; the valid bits are cleared on every request.
  - Latency is always 3 bus bytes plus 1 cycle (zero-wait: iack_o at n+4).
  - Port list is unchanged.

## Test plan
- **Cold miss:** reset, ROM[0100..0102]=02,12,34, istb_i=1 with iadr_i=0100, zero-wait bus.
  - Bus addresses 0100, 0101, 0102 on consecutive cycles.
  - iack_o at n+4 with op1_x..op3_x = 02,12,34.
- **Repeat and shift-reuse:** exact repeat of 0100, then 0101 (REUSE_EN).
  - Exact repeat: iack_o at n+1, no bus activity.
  - Request 0101: exactly one bus read at 0102+1=0103; outputs 12,34,ROM[0103].
- **Wait states:** wbi_ack_i delayed 2 cycles per byte on a cold miss → iack_o at n+10; wbi_adr_o stable while waiting.
- **Wrap:** iadr_i=FFFF → bus addresses FFFF, 0000, 0001; outputs in that order.
- **Abort:** istb_i dropped after the first ack of a 3-byte miss.
  - The second byte's cycle completes, then cyc=0 and no iack_o.
  - Re-request of the same address fetches only byte index 2 (REUSE_EN).
- **Reset and non-reuse build:**
  - rst asserted mid-FETCH → all outputs 0 at once; the next request is a full miss.
  - Build without `OC8051_IFETCH_REUSE_EN` → the repeated request to 0100 does 3 bus reads.
